// File: rtl/c4_pkg.sv
// Shared types and board constants for the Connect Four move sequencer.
package c4_pkg;

  localparam int NUM_COLS   = 7;
  localparam int CENTER_COL = 3;
  localparam int ROWS       = 6;

  typedef enum logic [2:0] {
    IDLE,
    IDLE_WAIT,
    CHECK,
    STEP,
    SETTLE,
    RESULT
  } state_t;

  typedef enum logic [1:0] {
    ST_OK     = 2'b00,
    ST_FULL   = 2'b01,
    ST_BADCOL = 2'b10,
    ST_OVER   = 2'b11
  } status_t;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/c4_turn_arbiter.sv
// Picks the request of the player whose turn it is and holds owner/target
// for the duration of a move sequence.
module c4_turn_arbiter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req_valid,
  input  logic [2:0] i_req_col0,
  input  logic [2:0] i_req_col1,
  input  logic       i_core_player,
  input  logic       i_latch,
  output logic       o_sel_valid,
  output logic [2:0] o_sel_col,
  output logic       o_owner,
  output logic [2:0] o_target
);

  logic       r_owner;
  logic [2:0] r_target;

  assign o_sel_valid = i_req_valid[i_core_player];
  assign o_sel_col   = i_core_player ? i_req_col1 : i_req_col0;
  assign o_owner     = r_owner;
  assign o_target    = r_target;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner  <= 1'b0;
      r_target <= '0;
    end else if (i_latch) begin
      r_owner  <= i_core_player;
      r_target <= o_sel_col;
    end
  end

endmodule

// File: rtl/c4_move_sequencer.sv
// Steps the game core's cursor to a requested column and reports the outcome.
// Build option: define C4_AUTO_START_EN to leave START without start_req.
module c4_move_sequencer
  import c4_pkg::*;
#(
  parameter int NUM_COLS   = c4_pkg::NUM_COLS,
  parameter int SETTLE_CYC = 1,
  parameter int RESULT_CYC = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req_valid,
  input  logic [2:0] req_col0,
  input  logic [2:0] req_col1,
  input  logic       start_req,
  output logic [1:0] req_ack,
  output logic [1:0] req_status,
  output logic       Left,
  output logic       Right,
  output logic       Select,
  output logic       Start,
  output logic       busy,
  input  logic [2:0] core_col,
  input  logic       core_player,
  input  logic       core_start,
  input  logic       core_end
);

  localparam logic [1:0] LP_SETTLE_LAST = 2'(SETTLE_CYC - 1);
  localparam logic [1:0] LP_RESULT_LAST = 2'(RESULT_CYC - 1);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_req_ack, w_ack_nxt;
  status_t    r_status, w_status_nxt;
  logic       r_left, r_right, r_select, r_start, r_busy;
  logic       w_left_nxt, w_right_nxt, w_select_nxt, w_start_nxt;
  logic       w_latch, w_sel_valid, w_owner, w_start_cond;
  logic [2:0] w_sel_col, w_target;

  c4_turn_arbiter u_arb (
    .i_clk         (Clk),
    .i_rst         (Reset),
    .i_req_valid   (req_valid),
    .i_req_col0    (req_col0),
    .i_req_col1    (req_col1),
    .i_core_player (core_player),
    .i_latch       (w_latch),
    .o_sel_valid   (w_sel_valid),
    .o_sel_col     (w_sel_col),
    .o_owner       (w_owner),
    .o_target      (w_target)
  );

`ifdef C4_AUTO_START_EN
  assign w_start_cond = core_start;
`else
  assign w_start_cond = core_start && start_req;
`endif

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ack_nxt    = '0;
    w_status_nxt = r_status;
    w_left_nxt   = 1'b0;
    w_right_nxt  = 1'b0;
    w_select_nxt = 1'b0;
    w_start_nxt  = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      IDLE: begin
        // An ack is on the wire this cycle; the source still shows valid.
        if (r_req_ack == 2'b00) begin
          if (w_start_cond) begin
            w_start_nxt = 1'b1;
            w_state_nxt = IDLE_WAIT;
          end else if (w_sel_valid && core_end) begin
            w_ack_nxt    = owner_onehot(core_player);
            w_status_nxt = ST_OVER;
          end else if (w_sel_valid) begin
            w_latch     = 1'b1;
            w_state_nxt = CHECK;
          end
        end
      end
      IDLE_WAIT: w_state_nxt = IDLE;
      CHECK: begin
        if (int'(w_target) >= NUM_COLS) begin
          w_ack_nxt    = owner_onehot(w_owner);
          w_status_nxt = ST_BADCOL;
          w_state_nxt  = IDLE;
        end else begin
          w_state_nxt = STEP;
        end
      end
      STEP: begin
        w_cnt_nxt = '0;
        if (core_col < w_target) begin
          w_right_nxt = 1'b1;
          w_state_nxt = SETTLE;
        end else if (core_col > w_target) begin
          w_left_nxt  = 1'b1;
          w_state_nxt = SETTLE;
        end else begin
          w_select_nxt = 1'b1;
          w_state_nxt  = RESULT;
        end
      end
      SETTLE: begin
        if (r_cnt == LP_SETTLE_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = STEP;
        end else begin
          w_cnt_nxt = r_cnt + 2'd1;
        end
      end
      RESULT: begin
        if (r_cnt == LP_RESULT_LAST) begin
          w_cnt_nxt = '0;
          if (core_end)                  w_status_nxt = ST_OVER;
          else if (core_player != w_owner) w_status_nxt = ST_OK;
          else                           w_status_nxt = ST_FULL;
          w_ack_nxt   = owner_onehot(w_owner);
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 2'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_req_ack <= '0;
      r_status  <= ST_OK;
      r_left    <= 1'b0;
      r_right   <= 1'b0;
      r_select  <= 1'b0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_req_ack <= w_ack_nxt;
      r_status  <= w_status_nxt;
      r_left    <= w_left_nxt;
      r_right   <= w_right_nxt;
      r_select  <= w_select_nxt;
      r_start   <= w_start_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign req_ack    = r_req_ack;
  assign req_status = r_status;
  assign Left       = r_left;
  assign Right      = r_right;
  assign Select     = r_select;
  assign Start      = r_start;
  assign busy       = r_busy;

endmodule

// File: tb/tb_c4_move_sequencer.sv
// Directed bench for c4_move_sequencer with a small behavioural game-core model.
module tb_c4_move_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] req_valid;
  logic [2:0] req_col0, req_col1;
  logic       start_req;
  logic [1:0] req_ack, req_status;
  logic       Left, Right, Select, Start, busy;
  logic [2:0] core_col;
  logic       core_player, core_start, core_end;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int start_cycle = 0;
  int heights[7];
  int n_right, n_left, n_select, n_start, n_both, n_ack, n_ack0, n_b2b;
  int first_right, last_right, ack_lat;
  logic got, prev_ack_nz;
  logic [1:0] last_ack, last_status;
  logic [1:0] ack_a;
  logic       seen_right;

  c4_move_sequencer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .req_valid   (req_valid),
    .req_col0    (req_col0),
    .req_col1    (req_col1),
    .start_req   (start_req),
    .req_ack     (req_ack),
    .req_status  (req_status),
    .Left        (Left),
    .Right       (Right),
    .Select      (Select),
    .Start       (Start),
    .busy        (busy),
    .core_col    (core_col),
    .core_player (core_player),
    .core_start  (core_start),
    .core_end    (core_end)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_right = 0; n_left = 0; n_select = 0; n_start = 0; n_ack = 0; n_ack0 = 0;
    first_right = -1; last_right = -1; got = 1'b0; start_cycle = cycle;
  endtask

  // One clock: observe outputs mid-cycle, then apply the core's response.
  task automatic cyc();
    logic r, l, s, st;
    logic [1:0] a;
    @(negedge Clk);
    r = Right; l = Left; s = Select; st = Start; a = req_ack;
    if (r) begin
      n_right++;
      if (first_right < 0) first_right = cycle;
      last_right = cycle;
    end
    if (l) n_left++;
    if (l && r) n_both++;
    if (s) n_select++;
    if (st) n_start++;
    if (a != 2'b00) begin
      got = 1'b1; last_ack = a; last_status = req_status;
      ack_lat = cycle - start_cycle; n_ack++;
      if (a[0]) n_ack0++;
      if (prev_ack_nz) n_b2b++;
    end
    prev_ack_nz = (a != 2'b00);
    @(posedge Clk);
    #1;
    cycle++;
    if (r && core_col < 3'd6) core_col = core_col + 3'd1;
    if (l && core_col > 3'd0) core_col = core_col - 3'd1;
    if (s && heights[int'(core_col)] < 6) begin
      heights[int'(core_col)]++;
      core_player = ~core_player;
    end
    if (st) core_start = 1'b0;
    req_valid = req_valid & ~a;
  endtask

  task automatic wait_ack(input string tag, input int budget);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) cyc();
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
  endtask

  task automatic request(input logic p, input logic [2:0] col);
    clear_stats();
    if (p) req_col1 = col; else req_col0 = col;
    req_valid[p] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 7; i++) heights[i] = 0;
    n_both = 0; n_b2b = 0; prev_ack_nz = 1'b0;
    last_ack = '0; last_status = '0; ack_lat = 0;
    Reset = 1'b1; req_valid = '0; req_col0 = '0; req_col1 = '0; start_req = 1'b0;
    core_col = 3'd3; core_player = 1'b0; core_start = 1'b0; core_end = 1'b0;
    clear_stats();
    #12;
    check("rst_outputs", 32'({req_ack, req_status, Left, Right, Select, Start, busy}), 32'd0);
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;

    // Player 0 to column 5 from column 3: two Rights, then Select.
    request(1'b0, 3'd5);
    wait_ack("p0_col5", 40);
    check("p0_col5_ack", 32'(last_ack), 32'h1);
    check("p0_col5_status", 32'(last_status), 32'h0);
    check("p0_col5_rights", 32'(n_right), 32'd2);
    check("p0_col5_right_gap", 32'(last_right - first_right), 32'd2);
    check("p0_col5_selects", 32'(n_select), 32'd1);
    check("p0_col5_latency", 32'(ack_lat), 32'd10);
    check("p0_col5_player", 32'(core_player), 32'd1);

    // Player 1 to column 0 from column 3: three Lefts, no Right.
    core_col = 3'd3;
    request(1'b1, 3'd0);
    wait_ack("p1_col0", 40);
    check("p1_col0_ack", 32'(last_ack), 32'h2);
    check("p1_col0_status", 32'(last_status), 32'h0);
    check("p1_col0_lefts", 32'(n_left), 32'd3);
    check("p1_col0_rights", 32'(n_right), 32'd0);
    check("p1_col0_col", 32'(core_col), 32'd0);

    // Out-of-range column is rejected without touching the core.
    request(1'b0, 3'd7);
    wait_ack("badcol", 10);
    check("badcol_ack", 32'(last_ack), 32'h1);
    check("badcol_status", 32'(last_status), 32'h2);
    check("badcol_latency", 32'(ack_lat), 32'd2);
    check("badcol_pulses", 32'(n_left + n_right + n_select), 32'd0);

    // Game already over: acked straight from IDLE.
    core_end = 1'b1;
    request(1'b0, 3'd1);
    wait_ack("over", 10);
    check("over_status", 32'(last_status), 32'h3);
    check("over_latency", 32'(ack_lat), 32'd1);
    check("over_selects", 32'(n_select), 32'd0);
    core_end = 1'b0;

    // Fill column 2, then one more request finds it full.
    for (int k = 0; k < 6; k++) begin
      request(core_player, 3'd2);
      wait_ack("fill", 40);
      check("fill_status", 32'(last_status), 32'h0);
    end
    request(core_player, 3'd2);
    wait_ack("full", 40);
    check("full_status", 32'(last_status), 32'h1);
    check("full_selects", 32'(n_select), 32'd1);
    check("full_player", 32'(core_player), 32'd0);

    // Both sources valid: only the turn owner is served.
    core_player = 1'b1;
    clear_stats();
    req_col0 = 3'd4; req_col1 = 3'd6; req_valid = 2'b11;
    wait_ack("both_first", 40);
    check("both_first_ack", 32'(last_ack), 32'h2);
    check("both_src0_unacked", 32'(n_ack0), 32'd0);
    check("both_src0_pending", 32'(req_valid[0]), 32'd1);
    check("both_first_col", 32'(core_col), 32'd6);
    clear_stats();
    wait_ack("both_second", 40);
    check("both_second_ack", 32'(last_ack), 32'h1);
    check("both_second_col", 32'(core_col), 32'd4);

    // START handling.
    clear_stats();
    core_start = 1'b1;
    repeat (4) cyc();
`ifdef C4_AUTO_START_EN
    check("start_no_req", 32'(n_start), 32'd1);
`else
    check("start_no_req", 32'(n_start), 32'd0);
`endif
    start_req = 1'b1;
    repeat (4) cyc();
    start_req = 1'b0;
    check("start_total", 32'(n_start), 32'd1);
    check("start_core_left", 32'(core_start), 32'd0);

    check("never_left_and_right", 32'(n_both), 32'd0);
    check("no_back_to_back_ack", 32'(n_b2b), 32'd0);

    // Reset while SETTLE is holding a Right pulse.
    request(core_player, 3'd6);
    seen_right = 1'b0;
    for (int i = 0; i < 20 && !seen_right; i++) begin
      @(negedge Clk);
      seen_right = Right;
    end
    check("rst_mid_reached_settle", 32'(seen_right), 32'd1);
    Reset = 1'b1;
    req_valid = '0;
    #1;
    check("rst_mid_outputs", 32'({req_ack, req_status, Left, Right, Select, Start, busy}), 32'd0);
    @(negedge Clk); Reset = 1'b0;
    @(negedge Clk);
    check("rst_mid_idle", 32'(busy), 32'd0);
    ack_a = req_ack;
    @(negedge Clk);
    check("rst_mid_no_ack", 32'({ack_a, req_ack, busy}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
